bkg_scroll_ram: RTL

BKG_SCROLL_RAM -- requirements
Module: bkg_scroll_ram

---
 rtl/bkg_scroll_ram.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/bkg_scroll_ram.sv
// Banked background pixel store with a palette lookup and a vertically scrolled read pipeline.
// A reset or clear request starts a sweep that zeroes every bank, one address per cycle.
module bkg_scroll_ram #(
  parameter int unsigned IMG_W     = 160,
  parameter int unsigned IMG_H     = 160,
  parameter int unsigned IDX_W     = 5,
  parameter int unsigned NUM_BANKS = 4,
  parameter int unsigned ADDR_W    = 15,
  localparam int unsigned BANK_W   = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [BANK_W-1:0] wr_bank,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [IDX_W-1:0]  wr_data,
  input  logic              pal_we,
  input  logic [IDX_W-1:0]  pal_addr,
  input  logic [23:0]       pal_data,
  input  logic              rd_valid_in,
  input  logic [BANK_W-1:0] rd_bank,
  input  logic [7:0]        rd_x,
  input  logic [7:0]        rd_y,
  input  logic [7:0]        scroll_y,
  output logic              rd_valid_out,
  output logic [23:0]       rgb_out,
  input  logic              clear_req,
  output logic              busy
);

  localparam int unsigned DEPTH = IMG_W * IMG_H;
  localparam int unsigned PAL_N = 2 ** IDX_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   cnt;

  logic                wq_valid;
  logic                wq_all;
  logic [BANK_W-1:0]   wq_bank;
  logic [ADDR_W-1:0]   wq_addr;
  logic [IDX_W-1:0]    wq_data;

  logic                s1_valid;
  logic                s1_oob;
  logic [BANK_W-1:0]   s1_bank;
  logic [ADDR_W-1:0]   s1_addr;
  logic                s2_valid;
  logic                s2_oob;
  logic [BANK_W-1:0]   s2_bank;

  logic                oob_c;
  logic [ADDR_W-1:0]   addr_c;
  int unsigned         ys_c;
  int unsigned         lin_c;
  logic [IDX_W-1:0]    idx_c;
  logic                wr_in_range_c;

  logic [IDX_W-1:0]    bank_q [NUM_BANKS];
  logic [23:0]         palette [PAL_N];

  // Clear sweep FSM; busy/wr_ready are registered alongside the state
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= CLEAR;
      cnt      <= '0;
      busy     <= 1'b1;
      wr_ready <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (clear_req) begin
            state    <= CLEAR;
            cnt      <= '0;
            busy     <= 1'b1;
            wr_ready <= 1'b0;
          end
        end
        CLEAR: begin
          if (cnt == LAST) begin
            state    <= IDLE;
            busy     <= 1'b0;
            wr_ready <= 1'b1;
          end else begin
            cnt <= cnt + ADDR_W'(1);
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

  assign wr_in_range_c = (32'(wr_addr) < DEPTH);

  // Writes land one cycle late so they align with the stage-2 RAM read (read-before-write)
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wq_valid <= 1'b0;
      wq_all   <= 1'b0;
      wq_bank  <= '0;
      wq_addr  <= '0;
      wq_data  <= '0;
    end else if (state == CLEAR) begin
      wq_valid <= 1'b1;
      wq_all   <= 1'b1;
      wq_bank  <= '0;
      wq_addr  <= cnt;
      wq_data  <= '0;
    end else begin
      wq_valid <= wr_valid && wr_ready && wr_in_range_c;
      wq_all   <= 1'b0;
      wq_bank  <= wr_bank;
      wq_addr  <= wr_addr;
      wq_data  <= wr_data;
    end
  end

  // Stage 1 address: scroll offsets at or beyond the image height are ignored
  always_comb begin
    oob_c  = (32'(rd_x) >= IMG_W) || (32'(rd_y) >= IMG_H) || (32'(rd_bank) >= NUM_BANKS);
    ys_c   = 32'(rd_y);
    if (32'(scroll_y) < IMG_H) ys_c = ys_c + 32'(scroll_y);
    if (ys_c >= IMG_H) ys_c = ys_c - IMG_H;
    lin_c  = ys_c * IMG_W + 32'(rd_x);
    addr_c = oob_c ? '0 : ADDR_W'(lin_c);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_valid <= 1'b0;
      s1_oob   <= 1'b0;
      s1_bank  <= '0;
      s1_addr  <= '0;
      s2_valid <= 1'b0;
      s2_oob   <= 1'b0;
      s2_bank  <= '0;
    end else begin
      s1_valid <= rd_valid_in;
      s1_oob   <= oob_c;
      s1_bank  <= rd_bank;
      s1_addr  <= addr_c;
      s2_valid <= s1_valid;
      s2_oob   <= s1_oob;
      s2_bank  <= s1_bank;
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [IDX_W-1:0] mem [DEPTH];
    logic [IDX_W-1:0] q;
    logic             we_c;

    assign we_c = wq_valid && (wq_all || (wq_bank == BANK_W'(b)));

    always_ff @(posedge Clk) begin
      if (we_c) mem[wq_addr] <= wq_data;
      q <= mem[s1_addr];
    end

    assign bank_q[b] = q;
  end

  always_comb begin
    idx_c = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (s2_bank == BANK_W'(b)) idx_c = bank_q[b];
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < PAL_N; i++) palette[i] <= '0;
    end else if (pal_we) begin
      palette[pal_addr] <= pal_data;
    end
  end

  // Stage 3: palette lookup; rgb_out holds when no result is due
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rd_valid_out <= 1'b0;
      rgb_out      <= '0;
    end else begin
      rd_valid_out <= s2_valid;
      if (s2_valid) rgb_out <= s2_oob ? 24'h000000 : palette[idx_c];
    end
  end

endmodule
